// File: rtl/alu_cmd_scheduler_if.sv
// Handshake and data bundle between the command parser, the ALU and the
// result formatter on one side, and the command scheduler on the other.
interface alu_cmd_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_dtype;
  logic [4:0]  cmd_operator;
  logic [15:0] cmd_src1;
  logic [15:0] cmd_src2;
  logic [3:0]  alu_dtype;
  logic [4:0]  alu_operator;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_res;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  // Scheduler side
  modport slave (
    input  cmd_valid, cmd_dtype, cmd_operator, cmd_src1, cmd_src2,
    input  alu_done, alu_res, res_ready,
    output cmd_ready, alu_dtype, alu_operator, alu_src1, alu_src2, alu_start,
    output res_valid, res_data, res_err, busy
  );

  // Environment side: parser, ALU and result formatter
  modport master (
    output cmd_valid, cmd_dtype, cmd_operator, cmd_src1, cmd_src2,
    output alu_done, alu_res, res_ready,
    input  cmd_ready, alu_dtype, alu_operator, alu_src1, alu_src2, alu_start,
    input  res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/alu_cmd_scheduler.sv
// Command scheduler: buffers parsed commands in a FIFO, issues them to the
// ALU one at a time, waits for completion (with timeout) and hands the
// result to the TX formatter through a valid/ready handshake.
module alu_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                clk,
  input logic                rst,
  alu_cmd_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // A command is legal for signed/unsigned add, sub, mul and div only.
  function automatic logic cmd_is_legal(input logic [3:0] dtype, input logic [4:0] op);
    logic dtype_ok;
    logic op_ok;
    dtype_ok = (dtype == 4'd1) || (dtype == 4'd2);
    op_ok    = (op >= 5'd1) && (op <= 5'd4);
    return dtype_ok && op_ok;
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [40:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [AW:0]   wr_ptr_next_s;
  logic [AW:0]   rd_ptr_next_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          fifo_empty_next_s;
  logic          fifo_full_next_s;
  logic          push_s;
  logic          pop_s;
  logic [40:0]   head_s;
  logic          head_legal_s;
  logic          issue_legal_s;
  logic          done_ok_s;
  logic          timeout_s;
  logic          alu_start_next_s;
  logic [CW-1:0] wait_cnt_r;
  logic [3:0]    alu_dtype_r;
  logic [4:0]    alu_operator_r;
  logic [15:0]   alu_src1_r;
  logic [15:0]   alu_src2_r;
  logic          alu_start_r;
  logic          res_valid_r;
  logic [31:0]   res_data_r;
  logic          res_err_r;
  logic          cmd_ready_r;
  logic          busy_r;

  // Pointers carry an extra MSB so full and empty are distinguishable.
  assign fifo_empty_s  = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_s        = bus.cmd_valid && !fifo_full_s;
  assign pop_s         = (state_r == IDLE) && !fifo_empty_s;
  assign head_s        = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign head_legal_s  = cmd_is_legal(head_s[40:37], head_s[36:32]);
  assign issue_legal_s = cmd_is_legal(alu_dtype_r, alu_operator_r);

  // The first WAIT cycle (counter 0) is a guard: the ALU has not yet latched
  // the operator, so a done seen there belongs to nothing we issued.
  assign done_ok_s = (state_r == WAIT) && (wait_cnt_r != CNT_ZERO) && bus.alu_done;
  assign timeout_s = (state_r == WAIT) && !done_ok_s && (wait_cnt_r == CNT_LAST);

  // Next FIFO pointers and the flags they imply, used to register outputs.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    fifo_empty_next_s = (wr_ptr_next_s == rd_ptr_next_s);
    fifo_full_next_s  = (wr_ptr_next_s[AW] != rd_ptr_next_s[AW]) &&
                        (wr_ptr_next_s[AW-1:0] == rd_ptr_next_s[AW-1:0]);
  end

  // Next-state logic of the issue/wait/hold sequencer.
  always_comb begin
    state_next_s     = state_r;
    alu_start_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s     = ISSUE;
          alu_start_next_s = head_legal_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (issue_legal_s) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = HOLD;
        end
      end
      WAIT: begin
        if (done_ok_s || timeout_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = WAIT;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, FIFO pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wr_ptr_r    <= {(AW+1){1'b0}};
      rd_ptr_r    <= {(AW+1){1'b0}};
      alu_start_r <= 1'b0;
      res_valid_r <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      alu_start_r <= alu_start_next_s;
      res_valid_r <= (state_next_s == HOLD);
      cmd_ready_r <= !fifo_full_next_s;
      busy_r      <= !fifo_empty_next_s || (state_next_s != IDLE);
    end
  end

  // Command storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= {bus.cmd_dtype, bus.cmd_operator, bus.cmd_src1, bus.cmd_src2};
    end
  end

  // Operand registers: loaded on the pop, held until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_dtype_r    <= 4'd0;
      alu_operator_r <= 5'd0;
      alu_src1_r     <= 16'd0;
      alu_src2_r     <= 16'd0;
    end else if (pop_s) begin
      alu_dtype_r    <= head_s[40:37];
      alu_operator_r <= head_s[36:32];
      alu_src1_r     <= head_s[31:16];
      alu_src2_r     <= head_s[15:0];
    end
  end

  // WAIT-cycle counter; cleared in every other state so each issue starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= CNT_ZERO;
    end else if (state_r == WAIT) begin
      wait_cnt_r <= wait_cnt_r + CW'(1'b1);
    end else begin
      wait_cnt_r <= CNT_ZERO;
    end
  end

  // Result capture: ALU result on done, zero plus error on timeout/illegal.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_r <= 32'd0;
      res_err_r  <= 1'b0;
    end else if ((state_r == ISSUE) && !issue_legal_s) begin
      res_data_r <= 32'd0;
      res_err_r  <= 1'b1;
    end else if (done_ok_s) begin
      res_data_r <= bus.alu_res;
      res_err_r  <= 1'b0;
    end else if (timeout_s) begin
      res_data_r <= 32'd0;
      res_err_r  <= 1'b1;
    end
  end

  assign bus.cmd_ready    = cmd_ready_r;
  assign bus.alu_dtype    = alu_dtype_r;
  assign bus.alu_operator = alu_operator_r;
  assign bus.alu_src1     = alu_src1_r;
  assign bus.alu_src2     = alu_src2_r;
  assign bus.alu_start    = alu_start_r;
  assign bus.res_valid    = res_valid_r;
  assign bus.res_data     = res_data_r;
  assign bus.res_err      = res_err_r;
  assign bus.busy         = busy_r;
endmodule
